// File: rtl/phy_rx.sv
// phy_rx: two-lane serial receiver, all logic in the clk_32f domain.
//
// Each lane shifts in one bit per cycle (MSB of each byte first). The lane
// hunts for the COMMA byte to find byte alignment and requires SYNC_COUNT
// consecutive aligned commas before it locks. Once both lanes are locked,
// every non-comma byte is packed into 32-bit words, MSB byte first. The
// finished words from the two lanes are then interleaved back into one
// stream, starting with lane 0.
//
// Handshake: data_out/valid_out form a push-only stream with no ready.
// valid_out is a single-cycle pulse that marks a new data_out value.
// data_out holds its value until the next pulse. Pulses are always separated
// by at least one low cycle.
//
// Ports:
//   clk_32f      in   1   bit clock, rising edge
//   reset        in   1   synchronous, active-high
//   phy_rx_in_0  in   1   serial lane 0
//   phy_rx_in_1  in   1   serial lane 1
//   data_out     out  32  reassembled word
//   valid_out    out  1   one-cycle pulse per new data_out
//   rx_active    out  1   both lanes locked (registered)
//   err_count    out  8   only when PHY_RX_ERR_CNT_EN is defined: saturating
//                         count of partial words discarded by a mid-word COMMA
//
// Optional feature macro: PHY_RX_ERR_CNT_EN.
module phy_rx #(
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  COMMA      = 8'hBC
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        phy_rx_in_0,
  input  logic        phy_rx_in_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        rx_active
`ifdef PHY_RX_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int SCW = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT + 1);

  logic [1:0]     w_in;
  state_t         r_state     [2];
  state_t         w_state_nxt [2];
  logic [SCW-1:0] r_sync_cnt  [2];
  logic [SCW-1:0] w_sync_nxt  [2];
  logic [2:0]     r_bit_cnt   [2];
  logic [2:0]     w_bit_nxt   [2];
  logic [7:0]     r_shift     [2];
  logic [7:0]     w_shift_nxt [2];
  logic           w_boundary  [2];
  logic [7:0]     r_byte      [2];
  logic           r_byte_vld  [2];
  logic [23:0]    r_word      [2];
  logic [1:0]     r_byte_idx  [2];
  logic [31:0]    r_hold      [2];
  logic           r_held      [2];
  logic           w_word_done [2];
  logic           w_discard   [2];
  logic           w_emit;
  logic           r_ptr;
  logic           r_rx_active;
  logic [31:0]    r_data_out;
  logic           r_valid_out;

  assign w_in = {phy_rx_in_1, phy_rx_in_0};

  // Per-lane alignment FSM. Comma detection uses the shift value that
  // includes the bit being sampled on this edge. A match therefore lands on
  // the edge that samples the last bit of the comma.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      w_shift_nxt[l] = {r_shift[l][6:0], w_in[l]};
      w_boundary[l]  = (r_bit_cnt[l] == 3'd7);
      w_state_nxt[l] = r_state[l];
      w_sync_nxt[l]  = r_sync_cnt[l];
      w_bit_nxt[l]   = r_bit_cnt[l] + 3'd1;
      case (r_state[l])
        ST_SEARCH: begin
          if (w_shift_nxt[l] == COMMA) begin
            w_bit_nxt[l]   = 3'd0;
            w_sync_nxt[l]  = SCW'(1);
            w_state_nxt[l] = (SYNC_COUNT <= 1) ? ST_LOCKED : ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (w_boundary[l]) begin
            if (w_shift_nxt[l] != COMMA) begin
              w_state_nxt[l] = ST_SEARCH;
            end else if (r_sync_cnt[l] == SCW'(SYNC_COUNT - 1)) begin
              w_state_nxt[l] = ST_LOCKED;
            end else begin
              w_sync_nxt[l] = r_sync_cnt[l] + SCW'(1);
            end
          end
        end
        default: ;
      endcase
      // The byte register holds a byte captured on the previous edge. It is
      // consumed only while the link is active.
      w_word_done[l] = r_byte_vld[l] && r_rx_active &&
                       (r_byte[l] != COMMA) && (r_byte_idx[l] == 2'd3);
      w_discard[l]   = r_byte_vld[l] && r_rx_active &&
                       (r_byte[l] == COMMA) && (r_byte_idx[l] != 2'd0);
    end
  end

  // Un-striping takes the pointed lane only. The !r_valid_out term keeps
  // pulses apart, so a lane that is already waiting goes out one cycle later.
  assign w_emit = r_held[r_ptr] && !r_valid_out;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        r_state[l]    <= ST_SEARCH;
        r_sync_cnt[l] <= '0;
        r_bit_cnt[l]  <= 3'd0;
        r_shift[l]    <= 8'd0;
        r_byte[l]     <= 8'd0;
        r_byte_vld[l] <= 1'b0;
        r_word[l]     <= 24'd0;
        r_byte_idx[l] <= 2'd0;
        r_hold[l]     <= 32'd0;
        r_held[l]     <= 1'b0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        r_state[l]    <= w_state_nxt[l];
        r_sync_cnt[l] <= w_sync_nxt[l];
        r_bit_cnt[l]  <= w_bit_nxt[l];
        r_shift[l]    <= w_shift_nxt[l];
        r_byte_vld[l] <= (r_state[l] == ST_LOCKED) && w_boundary[l];
        if ((r_state[l] == ST_LOCKED) && w_boundary[l]) begin
          r_byte[l] <= w_shift_nxt[l];
        end
        if (r_byte_vld[l] && r_rx_active) begin
          if (r_byte[l] == COMMA) begin
            r_byte_idx[l] <= 2'd0;
          end else begin
            r_word[l]     <= {r_word[l][15:0], r_byte[l]};
            r_byte_idx[l] <= r_byte_idx[l] + 2'd1;
          end
        end
        // A fresh word takes priority over the clear from un-striping.
        if (w_word_done[l]) begin
          r_hold[l] <= {r_word[l], r_byte[l]};
          r_held[l] <= 1'b1;
        end else if (w_emit && (r_ptr == 1'(l))) begin
          r_held[l] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_data_out  <= 32'd0;
      r_valid_out <= 1'b0;
      r_ptr       <= 1'b0;
      r_rx_active <= 1'b0;
    end else begin
      r_rx_active <= (r_state[0] == ST_LOCKED) && (r_state[1] == ST_LOCKED);
      r_valid_out <= w_emit;
      if (w_emit) begin
        r_data_out <= r_hold[r_ptr];
        r_ptr      <= ~r_ptr;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign rx_active = r_rx_active;

`ifdef PHY_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic [8:0] w_err_sum;

  assign w_err_sum = {1'b0, r_err_cnt} + {8'd0, w_discard[0]} + {8'd0, w_discard[1]};

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_err_cnt <= 8'd0;
    end else begin
      r_err_cnt <= (w_err_sum > 9'd255) ? 8'd255 : w_err_sum[7:0];
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_phy_rx.sv
// tb_phy_rx: self-checking bench for phy_rx.
// Both lanes are driven from per-lane bit queues. A lane with an empty queue
// sends COMMA, so the idle pattern stays byte-aligned with the traffic.
// Expected words are queued per lane as they are sent. The two lane queues
// are read in alternation, starting with lane 0, to give the output order.
// The discard count is modelled as a saturating tally of partial words cut
// short by a COMMA. The bench also needs PHY_RX_ERR_CNT_EN for err_count.
module tb_phy_rx;

  localparam int unsigned SYNC_COUNT = 4;
  localparam logic [7:0]  COMMA      = 8'hBC;

  logic        clk_32f = 1'b0;
  logic        reset = 1'b1;
  logic        phy_rx_in_0 = 1'b0;
  logic        phy_rx_in_1 = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        rx_active;
`ifdef PHY_RX_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  // clock / reset block
  always #5 clk_32f = ~clk_32f;

  phy_rx #(.SYNC_COUNT(SYNC_COUNT), .COMMA(COMMA)) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .phy_rx_in_0 (phy_rx_in_0),
    .phy_rx_in_1 (phy_rx_in_1),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .rx_active   (rx_active)
`ifdef PHY_RX_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  // scoreboard state
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        bits0[$];
  logic        bits1[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic        exp_ptr = 1'b0;
  int          exp_err = 0;
  logic        prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic count_discard();
    exp_err = (exp_err + 1 > 255) ? 255 : exp_err + 1;
  endtask

  // driver tasks
  task automatic push_byte(input int lane, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (lane == 0) bits0.push_back(b[i]);
      else           bits1.push_back(b[i]);
    end
  endtask

  task automatic add_word(input int lane, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) push_byte(lane, w[8*i +: 8]);
    if (lane == 0) exp_q0.push_back(w);
    else           exp_q1.push_back(w);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (b == COMMA);
    return b;
  endfunction

  function automatic logic [31:0] rand_word();
    return {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
  endfunction

  // Output monitor: every pulse is matched against the lane that is due next.
  task automatic monitor();
    logic [31:0] w;
    if (valid_out === 1'b1) begin
      check("valid_spacing", 32'(prev_valid), 32'd0);
      if (exp_ptr == 1'b0 && exp_q0.size() > 0) begin
        w = exp_q0.pop_front();
        check("data_lane0", data_out, w);
        exp_ptr = 1'b1;
      end else if (exp_ptr == 1'b1 && exp_q1.size() > 0) begin
        w = exp_q1.pop_front();
        check("data_lane1", data_out, w);
        exp_ptr = 1'b0;
      end else begin
        check("spurious_valid", 32'(valid_out), 32'd0);
      end
    end
    prev_valid = valid_out;
  endtask

  // One bit per lane. Drive at the negedge, then look at outputs on the next negedge.
  task automatic tick();
    if (bits0.size() == 0) push_byte(0, COMMA);
    if (bits1.size() == 0) push_byte(1, COMMA);
    phy_rx_in_0 = bits0.pop_front();
    phy_rx_in_1 = bits1.pop_front();
    @(posedge clk_32f);
    @(negedge clk_32f);
    monitor();
  endtask

  task automatic drain_bits();
    while (bits0.size() > 0 || bits1.size() > 0) tick();
  endtask

  task automatic wait_words(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size()) > 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bits0.delete();
    bits1.delete();
    for (int i = 0; i < n; i++) begin
      phy_rx_in_0 = 1'($urandom_range(0, 1));
      phy_rx_in_1 = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      @(negedge clk_32f);
      check("reset_data_out", data_out, 32'd0);
      check("reset_valid_out", 32'(valid_out), 32'd0);
      check("reset_rx_active", 32'(rx_active), 32'd0);
`ifdef PHY_RX_ERR_CNT_EN
      check("reset_err_count", 32'(err_count), 32'd0);
`endif
    end
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    exp_ptr    = 1'b0;
    exp_err    = 0;
    prev_valid = 1'b0;
  endtask

  // Zero prefix bits, then commas. The lock lands on bit offset+8*SYNC_COUNT-1,
  // and rx_active is expected one bit later.
  task automatic lock_seq(input int offset);
    logic any_early;
    int   last;
    any_early = 1'b0;
    last = offset + 8 * int'(SYNC_COUNT) - 1;
    for (int i = 0; i < offset; i++) begin
      bits0.push_back(1'b0);
      bits1.push_back(1'b0);
    end
    for (int k = 0; k < int'(SYNC_COUNT) + 1; k++) begin
      push_byte(0, COMMA);
      push_byte(1, COMMA);
    end
    for (int t = 0; t <= last; t++) begin
      tick();
      if (t == 0) begin
        check("post_reset_data_out", data_out, 32'd0);
        check("post_reset_valid_out", 32'(valid_out), 32'd0);
        check("post_reset_rx_active", 32'(rx_active), 32'd0);
      end
      any_early = any_early | rx_active;
    end
    check("rx_active_before_lock", 32'(any_early), 32'd0);
    tick();
    check("rx_active_after_lock", 32'(rx_active), 32'd1);
  endtask

  initial begin
    // reset with random serial input
    do_reset(3);

    // lock at a 3-bit offset
    lock_seq(3);
    drain_bits();
    check("idle_no_valid", 32'(valid_out), 32'd0);

    // two words with identical timing on both lanes
    add_word(0, 32'h11223344);
    add_word(1, 32'h55667788);
    for (int t = 1; t <= 33; t++) tick();
    check("word0_not_before_e2", 32'(valid_out), 32'd0);
    tick();
    check("word0_valid_at_e2", 32'(valid_out), 32'd1);
    wait_words("two_words_emitted", 20);
    for (int t = 0; t < 16; t++) tick();
    check("data_out_held", data_out, 32'h55667788);
    check("valid_low_when_idle", 32'(valid_out), 32'd0);

    // mid-word comma on lane 0
    drain_bits();
    push_byte(0, 8'hAA);
    push_byte(0, 8'hBB);
    push_byte(0, COMMA);
    count_discard();
    add_word(0, 32'h01020304);
    wait_words("midword_word_emitted", 120);
    for (int t = 0; t < 16; t++) tick();
`ifdef PHY_RX_ERR_CNT_EN
    check("err_after_midword", 32'(err_count), 32'(exp_err));
`endif

    // randomized rounds: idles, optional partial word, then one word per lane
    for (int r = 0; r < 20; r++) begin
      drain_bits();
      for (int l = 0; l < 2; l++) begin
        int n_idle;
        n_idle = $urandom_range(0, 2);
        for (int i = 0; i < n_idle; i++) push_byte(l, COMMA);
        if ($urandom_range(0, 1) == 1) begin
          int p;
          p = $urandom_range(1, 3);
          for (int i = 0; i < p; i++) push_byte(l, rand_byte());
          push_byte(l, COMMA);
          count_discard();
        end
        add_word(l, rand_word());
        push_byte(l, COMMA);
      end
    end
    drain_bits();
    wait_words("random_words_emitted", 200);
    for (int t = 0; t < 4; t++) tick();
`ifdef PHY_RX_ERR_CNT_EN
    check("err_after_random", 32'(err_count), 32'(exp_err));
`endif

    // reset after 2 bytes of a word, then re-lock at a random offset
    drain_bits();
    for (int l = 0; l < 2; l++) begin
      push_byte(l, rand_byte());
      push_byte(l, rand_byte());
    end
    for (int t = 0; t < 18; t++) tick();
    do_reset(2);
    lock_seq($urandom_range(1, 7));
    drain_bits();
    add_word(0, rand_word());
    add_word(1, rand_word());
    wait_words("relock_words_emitted", 60);

`ifdef PHY_RX_ERR_CNT_EN
    // 300 discards, 2 at a time, must saturate at 255
    for (int r = 0; r < 150; r++) begin
      for (int l = 0; l < 2; l++) begin
        push_byte(l, rand_byte());
        push_byte(l, COMMA);
        count_discard();
      end
      drain_bits();
    end
    for (int t = 0; t < 2; t++) tick();
    check("err_saturated", 32'(err_count), 32'(exp_err));
    check("err_saturated_255", 32'(err_count), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
